// File: rtl/exec_iter.sv
// Iterative execute unit: single-cycle ADD/SUB, shift-add multiply and restoring
// divide at one bit per cycle, with operand forwarding and a valid/ready output.
module exec_iter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [1:0]       fwd_A_sel,
    input  logic [1:0]       fwd_B_sel,
    input  logic [WIDTH-1:0] xm_data,
    input  logic [WIDTH-1:0] mw_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 hiSel_q, hiSel_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH-1:0]     srcA, srcB;
    logic                 accept;
    logic [WIDTH:0]       mulSum;
    logic [WIDTH:0]       divShift;
    logic [WIDTH:0]       divDiff;
    logic                 divFits;
    logic [WIDTH-1:0]     remNext;

    always_comb begin
        unique case (fwd_A_sel)
            2'b01:   srcA = xm_data;
            2'b10:   srcA = mw_data;
            default: srcA = inA;
        endcase
        unique case (fwd_B_sel)
            2'b01:   srcB = xm_data;
            2'b10:   srcB = mw_data;
            default: srcB = inB;
        endcase
    end

    assign in_ready = (state_q == IDLE) & (~out_valid_q | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q == MUL) | (state_q == DIV);

    // prod_q holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    assign mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign divShift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, opnd_q};
    assign divFits  = divShift >= {1'b0, opnd_q};
    assign remNext  = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opnd_d      = opnd_q;
        prod_d      = prod_q;
        hiSel_d     = hiSel_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        div_zero_d  = div_zero_q;

        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            div_zero_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        div_zero_d  = 1'b0;
                    end
                    if (accept) begin
                        hiSel_d = op[0];
                        cnt_d   = '0;
                        unique case (op)
                            3'b010, 3'b011: begin
                                opnd_d  = srcA;
                                prod_d  = {{WIDTH{1'b0}}, srcB};
                                state_d = MUL;
                            end
                            3'b100, 3'b101: begin
                                if (srcB == '0) begin
                                    result_d    = op[0] ? srcA : {WIDTH{1'b1}};
                                    out_valid_d = 1'b1;
                                    div_zero_d  = 1'b1;
                                end else begin
                                    opnd_d  = srcB;
                                    prod_d  = {{WIDTH{1'b0}}, srcA};
                                    state_d = DIV;
                                end
                            end
                            3'b001: begin
                                result_d    = srcA - srcB;
                                out_valid_d = 1'b1;
                                div_zero_d  = 1'b0;
                            end
                            default: begin
                                result_d    = srcA + srcB;
                                out_valid_d = 1'b1;
                                div_zero_d  = 1'b0;
                            end
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (state_q == MUL) prod_d = {mulSum, prod_q[WIDTH-1:1]};
                    else                prod_d = {remNext, prod_q[WIDTH-2:0], divFits};
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    result_d    = hiSel_q ? prod_q[2*WIDTH-1:WIDTH] : prod_q[WIDTH-1:0];
                    out_valid_d = 1'b1;
                    div_zero_d  = 1'b0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opnd_q      <= '0;
            prod_q      <= '0;
            hiSel_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opnd_q      <= opnd_d;
            prod_q      <= prod_d;
            hiSel_q     <= hiSel_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_exec_iter.sv
// Directed bench for exec_iter: each scenario task drives vectors and compares
// against hand-computed values at WIDTH=16.
module tb_exec_iter;
    localparam int W = 16;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MULLO = 3'b010,
                           MULHI = 3'b011, DIVU = 3'b100, REMU = 3'b101;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, flush, out_valid, out_ready, div_zero, busy;
    logic [2:0]   op;
    logic [W-1:0] inA, inB, xm_data, mw_data, result;
    logic [1:0]   fwd_A_sel, fwd_B_sel;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    exec_iter #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .inA(inA), .inB(inB), .fwd_A_sel(fwd_A_sel), .fwd_B_sel(fwd_B_sel),
        .xm_data(xm_data), .mw_data(mw_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .div_zero(div_zero), .busy(busy)
    );

    task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid  = v;
        op        = o;
        inA       = a;
        inB       = b;
        fwd_A_sel = 2'b00;
        fwd_B_sel = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1; xm_data = '0; mw_data = '0;
        drive(1'b0, ADD, '0, '0);
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", result); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got=%0b exp=0", div_zero); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_add_sub;
        @(negedge clk); drive(1'b1, ADD, 16'h7FFF, 16'h0001);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || result !== 16'h8000) begin failures++; $display("FAIL add got=%h v=%0b exp=8000", result, out_valid); end
        @(negedge clk); drive(1'b1, SUB, 16'h0003, 16'h0005);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || result !== 16'hFFFE) begin failures++; $display("FAIL sub got=%h v=%0b exp=fffe", result, out_valid); end
        @(negedge clk); drive(1'b0, ADD, '0, '0);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_retire got=%0b exp=0", out_valid); end
    endtask

    task automatic test_mul;
        logic [2:0]   opsL [2];
        logic [W-1:0] expL [2];
        int n, busyCnt;
        bit got;
        opsL[0] = MULLO; expL[0] = 16'h3400;
        opsL[1] = MULHI; expL[1] = 16'h0012;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(1'b1, opsL[i], 16'h1234, 16'h0100);
            @(posedge clk); #1;
            drive(1'b0, ADD, '0, '0);
            n = 0; busyCnt = busy ? 1 : 0; got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(posedge clk); #1;
                n++;
                if (busy) busyCnt++;
                if (out_valid) got = 1;
            end
            checks++; if (n !== 17) begin failures++; $display("FAIL mul_latency[%0d] got=%0d exp=17", i, n); end
            checks++; if (busyCnt !== 16) begin failures++; $display("FAIL mul_busy[%0d] got=%0d exp=16", i, busyCnt); end
            checks++; if (result !== expL[i]) begin failures++; $display("FAIL mul_result[%0d] got=%h exp=%h", i, result, expL[i]); end
        end
    endtask

    task automatic test_div;
        logic [2:0]   opsL [2];
        logic [W-1:0] expL [2];
        int n;
        bit got;
        opsL[0] = DIVU; expL[0] = 16'h000E;
        opsL[1] = REMU; expL[1] = 16'h0002;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(1'b1, opsL[i], 16'd100, 16'd7);
            @(posedge clk); #1;
            drive(1'b0, ADD, '0, '0);
            n = 0; got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(posedge clk); #1;
                n++;
                if (out_valid) got = 1;
            end
            checks++; if (n !== 17) begin failures++; $display("FAIL div_latency[%0d] got=%0d exp=17", i, n); end
            checks++; if (result !== expL[i] || div_zero !== 1'b0) begin failures++; $display("FAIL div_result[%0d] got=%h dz=%0b exp=%h dz=0", i, result, div_zero, expL[i]); end
        end
        @(negedge clk); drive(1'b1, DIVU, 16'd5, 16'd0);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || result !== 16'hFFFF || div_zero !== 1'b1) begin failures++; $display("FAIL divu_zero got=%h v=%0b dz=%0b exp=ffff v=1 dz=1", result, out_valid, div_zero); end
        @(negedge clk); drive(1'b1, REMU, 16'd5, 16'd0);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || result !== 16'h0005 || div_zero !== 1'b1) begin failures++; $display("FAIL remu_zero got=%h v=%0b dz=%0b exp=0005 v=1 dz=1", result, out_valid, div_zero); end
        @(negedge clk); drive(1'b1, ADD, 16'd5, 16'd0);
        @(posedge clk); #1;
        checks++; if (result !== 16'h0005 || div_zero !== 1'b0) begin failures++; $display("FAIL dz_clear got=%h dz=%0b exp=0005 dz=0", result, div_zero); end
        @(negedge clk); drive(1'b0, ADD, '0, '0);
    endtask

    task automatic test_forward;
        @(negedge clk); drive(1'b1, ADD, 16'h1111, 16'h2222);
        fwd_A_sel = 2'b01; fwd_B_sel = 2'b10; xm_data = 16'h0010; mw_data = 16'h0020;
        @(posedge clk); #1;
        checks++; if (result !== 16'h0030) begin failures++; $display("FAIL fwd_xm_mw got=%h exp=0030", result); end
        @(negedge clk); drive(1'b1, ADD, 16'h1111, 16'h2222);
        fwd_A_sel = 2'b11; fwd_B_sel = 2'b11;
        @(posedge clk); #1;
        checks++; if (result !== 16'h3333) begin failures++; $display("FAIL fwd_sel11 got=%h exp=3333", result); end
        @(negedge clk); drive(1'b0, ADD, '0, '0);
    endtask

    task automatic test_backpressure;
        @(negedge clk); out_ready = 1'b0; drive(1'b1, ADD, 16'd1, 16'd2);
        @(posedge clk); #1;
        drive(1'b1, ADD, 16'd10, 16'd20);
        checks++; if (out_valid !== 1'b1 || result !== 16'h0003) begin failures++; $display("FAIL bp_first got=%h v=%0b exp=0003 v=1", result, out_valid); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (result !== 16'h0003 || out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold[%0d] got=%h v=%0b rdy=%0b exp=0003 v=1 rdy=0", c, result, out_valid, in_ready); end
        end
        @(negedge clk); out_ready = 1'b1; drive(1'b0, ADD, '0, '0);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready got=%0b exp=1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_retire got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush;
        int seen;
        @(negedge clk); drive(1'b1, ADD, 16'd1, 16'd1);
        @(posedge clk); #1; drive(1'b0, ADD, '0, '0);
        @(negedge clk); drive(1'b1, MULLO, 16'd3, 16'd5);
        @(posedge clk); #1; drive(1'b0, ADD, '0, '0);
        repeat (8) @(posedge clk);
        @(negedge clk); flush = 1'b1; #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 16'h0002) begin failures++; $display("FAIL flush_mul got=%h busy=%0b v=%0b exp=0002 busy=0 v=0", result, busy, out_valid); end
        @(negedge clk); flush = 1'b0;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen !== 0) begin failures++; $display("FAIL flush_mul_quiet got=%0d exp=0", seen); end

        @(negedge clk); drive(1'b1, MULLO, 16'd3, 16'd5);
        @(posedge clk); #1; drive(1'b0, ADD, '0, '0);
        repeat (16) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || result !== 16'h0002) begin failures++; $display("FAIL flush_done got=%h v=%0b exp=0002 v=0", result, out_valid); end
        @(negedge clk); flush = 1'b0;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen !== 0) begin failures++; $display("FAIL flush_done_quiet got=%0d exp=0", seen); end
        @(negedge clk); drive(1'b1, ADD, 16'd4, 16'd5);
        @(posedge clk); #1; drive(1'b0, ADD, '0, '0);
        checks++; if (out_valid !== 1'b1 || result !== 16'h0009) begin failures++; $display("FAIL flush_next_add got=%h v=%0b exp=0009 v=1", result, out_valid); end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk); drive(1'b1, DIVU, 16'd100, 16'd7);
        @(posedge clk); #1; drive(1'b0, ADD, '0, '0);
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 16'h0000) begin failures++; $display("FAIL rst_mid got=%h busy=%0b v=%0b exp=0000 busy=0 v=0", result, busy, out_valid); end
        @(negedge clk); rst = 1'b1;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_quiet got=%0d exp=0", seen); end
        @(negedge clk); drive(1'b1, ADD, 16'd6, 16'd7);
        @(posedge clk); #1; drive(1'b0, ADD, '0, '0);
        checks++; if (out_valid !== 1'b1 || result !== 16'h000D) begin failures++; $display("FAIL rst_next_add got=%h v=%0b exp=000d v=1", result, out_valid); end
    endtask

    initial begin
        test_reset;
        test_add_sub;
        test_mul;
        test_div;
        test_forward;
        test_backpressure;
        test_flush;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
